// File: rtl/axis_arbiter_pkg.sv
// Shared constants and helpers for the AXI-Stream style request arbiter.
package axis_arbiter_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a binary index for n items; never narrower than one bit.
  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_arbiter_prio_enc.sv
// Combinational priority encoder: picks one set bit of request, reporting it
// as a valid flag, a binary index and a one-hot vector.
module axis_arbiter_prio_enc
  import axis_arbiter_pkg::*;
#(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 0
) (
  input  logic [WIDTH-1:0]             request,
  output logic                         valid,
  output logic [clog2_safe(WIDTH)-1:0] encoded,
  output logic [WIDTH-1:0]             one_hot
);

  localparam int EW = clog2_safe(WIDTH);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    valid   = 1'b0;
    encoded = '0;
    one_hot = '0;
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int unsigned i = WIDTH; i > 0; i--) begin
        if (request[i-1]) begin
          valid   = 1'b1;
          encoded = EW'(i - 1);
          one_hot = WIDTH'(1) << (i - 1);
        end
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (request[i]) begin
          valid   = 1'b1;
          encoded = EW'(i);
          one_hot = WIDTH'(1) << i;
        end
      end
    end
  end

endmodule

// File: rtl/axis_arbiter.sv
// Registered N-port arbiter with fixed-priority or round-robin selection and
// optional grant holding (released on acknowledge or on request drop).
// Define AXIS_ARBITER_ASSERT_EN to compile simulation assertions.
module axis_arbiter
  import axis_arbiter_pkg::*;
#(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 0,
  parameter int ARB_BLOCK             = 0,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORTS-1:0]             request,
  input  logic [PORTS-1:0]             acknowledge,
  output logic [PORTS-1:0]             grant,
  output logic                         grant_valid,
  output logic [clog2_safe(PORTS)-1:0] grant_encoded
);

  localparam int EW = clog2_safe(PORTS);
  localparam logic [PORTS-1:0] ONES = '1;

  logic [PORTS-1:0] mask;
  logic [PORTS-1:0] grant_next;
  logic [PORTS-1:0] mask_next;
  logic             valid_next;
  logic [EW-1:0]    enc_next;
  logic             hold;

  logic             u_valid;
  logic [EW-1:0]    u_enc;
  logic [PORTS-1:0] u_onehot;
  logic             m_valid;
  logic [EW-1:0]    m_enc;
  logic [PORTS-1:0] m_onehot;

  axis_arbiter_prio_enc #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_enc_unmasked (
    .request (request),
    .valid   (u_valid),
    .encoded (u_enc),
    .one_hot (u_onehot)
  );

  axis_arbiter_prio_enc #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_enc_masked (
    .request (request & mask),
    .valid   (m_valid),
    .encoded (m_enc),
    .one_hot (m_onehot)
  );

  // Decide whether the current grant must be kept this cycle.
  always_comb begin
    hold = 1'b0;
    if (ARB_BLOCK != 0) begin
      if (ARB_BLOCK_ACK != 0) hold = grant_valid && ((grant & acknowledge) == '0);
      else                    hold = (grant & request) != '0;
    end
  end

  // Next grant and round-robin mask; the mask only moves on a new grant.
  always_comb begin
    grant_next = grant;
    valid_next = grant_valid;
    enc_next   = grant_encoded;
    mask_next  = mask;
    if (!hold) begin
      if (u_valid) begin
        if (ARB_TYPE_ROUND_ROBIN == ARB_RR && m_valid) begin
          grant_next = m_onehot;
          enc_next   = m_enc;
        end else begin
          grant_next = u_onehot;
          enc_next   = u_enc;
        end
        valid_next = 1'b1;
        if (ARB_TYPE_ROUND_ROBIN == ARB_RR) begin
          // Shift amounts widened to 32 bits so k+1 cannot wrap in EW bits.
          if (ARB_LSB_HIGH_PRIORITY != 0) mask_next = ONES << (32'(enc_next) + 32'd1);
          else                            mask_next = ONES >> (PORTS - 32'(enc_next));
        end
      end else begin
        grant_next = '0;
        valid_next = 1'b0;
        enc_next   = '0;
      end
    end
  end

  // Output and mask registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '0;
    end else begin
      grant         <= grant_next;
      grant_valid   <= valid_next;
      grant_encoded <= enc_next;
      mask          <= mask_next;
    end
  end

`ifdef AXIS_ARBITER_ASSERT_EN
  logic [PORTS-1:0] request_q;
  logic [PORTS-1:0] grant_q;
  logic             hold_q;

  // Previous-cycle history for the checks below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      request_q <= '0;
      grant_q   <= '0;
      hold_q    <= 1'b0;
    end else begin
      request_q <= request;
      grant_q   <= grant;
      hold_q    <= hold;
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_valid:  assert property (@(posedge clk) disable iff (rst) grant_valid == (grant != '0));
  a_subset: assert property (@(posedge clk) disable iff (rst)
                             !hold_q |-> ((grant & ~request_q) == '0));
  a_hold:   assert property (@(posedge clk) disable iff (rst) hold_q |-> (grant == grant_q));
`else
`endif

endmodule

// File: tb/tb_axis_arbiter.sv
// Directed testbench for axis_arbiter across several parameter sets.
module tb_axis_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] request = '0;
  logic [3:0] acknowledge = '0;
  logic       p1_req = 1'b0;
  logic       p1_ack = 1'b0;

  logic [3:0] g_fl, g_fm, g_rl, g_rm, g_ba, g_br;
  logic       v_fl, v_fm, v_rl, v_rm, v_ba, v_br;
  logic [1:0] e_fl, e_fm, e_rl, e_rm, e_ba, e_br;
  logic       g_p1, v_p1, e_p1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axis_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_LSB_HIGH_PRIORITY(1))
    u_fix_lsb (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
               .grant(g_fl), .grant_valid(v_fl), .grant_encoded(e_fl));
  axis_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_LSB_HIGH_PRIORITY(0))
    u_fix_msb (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
               .grant(g_fm), .grant_valid(v_fm), .grant_encoded(e_fm));
  axis_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_LSB_HIGH_PRIORITY(1))
    u_rr_lsb (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
              .grant(g_rl), .grant_valid(v_rl), .grant_encoded(e_rl));
  axis_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_LSB_HIGH_PRIORITY(0))
    u_rr_msb (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
              .grant(g_rm), .grant_valid(v_rm), .grant_encoded(e_rm));
  axis_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                 .ARB_LSB_HIGH_PRIORITY(1))
    u_blk_ack (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
               .grant(g_ba), .grant_valid(v_ba), .grant_encoded(e_ba));
  axis_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                 .ARB_LSB_HIGH_PRIORITY(1))
    u_blk_req (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
               .grant(g_br), .grant_valid(v_br), .grant_encoded(e_br));
  axis_arbiter #(.PORTS(1), .ARB_TYPE_ROUND_ROBIN(1))
    u_p1 (.clk(clk), .rst(rst), .request(p1_req), .acknowledge(p1_ack),
          .grant(g_p1), .grant_valid(v_p1), .grant_encoded(e_p1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] rr_lsb_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_msb_seq [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

  initial begin
    // Reset state, before any clock edge.
    #2;
    check("rst_grant", 32'(g_fl), 32'h0);
    check("rst_valid", 32'(v_fl), 32'h0);
    check("rst_enc",   32'(e_rl), 32'h0);
    check("rst_p1",    32'(g_p1), 32'h0);
    do_reset();

    // Fixed priority, both directions.
    request = 4'b1010; p1_req = 1'b1;
    tick();
    check("fl_grant",  32'(g_fl), 32'b0010);
    check("fl_enc",    32'(e_fl), 32'd1);
    check("fl_valid",  32'(v_fl), 32'd1);
    check("fm_grant",  32'(g_fm), 32'b1000);
    check("fm_enc",    32'(e_fm), 32'd3);
    check("p1_grant",  32'(g_p1), 32'd1);
    check("p1_valid",  32'(v_p1), 32'd1);
    check("p1_enc",    32'(e_p1), 32'd0);
    request = 4'b0110;
    #1;
    check("fm_registered", 32'(g_fm), 32'b1000);
    tick();
    check("fm_grant2", 32'(g_fm), 32'b0100);
    check("fm_enc2",   32'(e_fm), 32'd2);
    request = 4'b0000; p1_req = 1'b0;
    tick();
    check("fl_idle_grant", 32'(g_fl), 32'h0);
    check("fl_idle_valid", 32'(v_fl), 32'h0);
    check("fl_idle_enc",   32'(e_fl), 32'h0);

    // Round robin rotation in both priority directions.
    do_reset();
    request = 4'b1111;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rrl_seq%0d", i), 32'(g_rl), 32'(rr_lsb_seq[i]));
      check($sformatf("rrm_seq%0d", i), 32'(g_rm), 32'(rr_msb_seq[i]));
    end
    check("rrl_enc_last", 32'(e_rl), 32'd0);
    request = 4'b0000;
    tick();
    check("rrl_idle", 32'(v_rl), 32'd0);
    request = 4'b1111;
    tick();
    check("rrl_mask_kept", 32'(g_rl), 32'b0010);
    do_reset();
    request = 4'b0101;
    tick();
    check("rrl_post_rst", 32'(g_rl), 32'b0001);

    // Hold until acknowledge.
    request = 4'b0000;
    do_reset();
    request = 4'b0100;
    tick();
    check("ba_grant", 32'(g_ba), 32'b0100);
    request = 4'b0001;
    tick();
    check("ba_hold1", 32'(g_ba), 32'b0100);
    tick();
    check("ba_hold2", 32'(g_ba), 32'b0100);
    acknowledge = 4'b0100;
    tick();
    check("ba_release", 32'(g_ba), 32'b0001);
    check("ba_rel_enc", 32'(e_ba), 32'd0);
    acknowledge = 4'b0010; request = 4'b0010;
    tick();
    check("ba_foreign_ack", 32'(g_ba), 32'b0001);
    acknowledge = 4'b0000;

    // Hold while request stays asserted.
    request = 4'b0000;
    do_reset();
    request = 4'b0001;
    tick();
    check("br_grant", 32'(g_br), 32'b0001);
    request = 4'b0011;
    tick();
    check("br_hold", 32'(g_br), 32'b0001);
    request = 4'b0010;
    tick();
    check("br_switch", 32'(g_br), 32'b0010);
    request = 4'b0011;
    tick();
    check("br_hold2", 32'(g_br), 32'b0010);
    request = 4'b0000;
    tick();
    check("br_drop", 32'(v_br), 32'd0);

    // Asynchronous reset in the middle of a hold.
    do_reset();
    request = 4'b1000;
    tick();
    check("ar_grant", 32'(g_ba), 32'b1000);
    #3 rst = 1'b1;
    #1;
    check("ar_grant0", 32'(g_ba), 32'h0);
    check("ar_valid0", 32'(v_ba), 32'h0);
    check("ar_enc0",   32'(e_ba), 32'h0);
    #2 rst = 1'b0;
    request = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_arbiter.md
AXIS_ARBITER -- requirements
Module: axis_arbiter

Interface
REQ-001 The module SHALL have parameter PORTS, default 4, giving the number of requesters (≥1).
REQ-002 The module SHALL have parameter ARB_TYPE_ROUND_ROBIN, default 0, where 0 selects fixed priority and 1 selects round robin.
REQ-003 The module SHALL have parameter ARB_BLOCK, default 0, where 1 holds the current grant under the blocking rules.
REQ-004 The module SHALL have parameter ARB_BLOCK_ACK, default 1, where 1 releases a blocking grant on acknowledge and 0 releases it on request drop.
REQ-005 The module SHALL have parameter ARB_LSB_HIGH_PRIORITY, default 0, where 1 gives the lowest index highest priority and 0 gives the highest index highest priority.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The module SHALL have port request, input, PORTS bits: one request bit per port.
REQ-009 The module SHALL have port acknowledge, input, PORTS bits: per-port release of a held grant.
REQ-010 The module SHALL have port grant, output, PORTS bits: one-hot or zero grant vector.
REQ-011 The module SHALL have port grant_valid, output, 1 bit: high when some grant bit is set.
REQ-012 The module SHALL have port grant_encoded, output, $clog2(PORTS) bits: binary index of the granted port.

Function
REQ-013 All outputs SHALL be registered, so a request change affects grant exactly 1 cycle later.
REQ-014 grant SHALL always be zero or one-hot; grant_valid SHALL equal OR(grant); grant_encoded SHALL equal the index of the set bit, or 0 when grant=0.
REQ-015 Hold (ARB_BLOCK=1, ARB_BLOCK_ACK=0): when (grant & request)≠0, the grant SHALL be kept unchanged.
REQ-016 Hold (ARB_BLOCK=1, ARB_BLOCK_ACK=1): when grant_valid=1 and (grant & acknowledge)=0, the grant SHALL be kept unchanged, even if the request drops.
REQ-017 When not holding and request≠0 with fixed priority, the highest-priority requester (per ARB_LSB_HIGH_PRIORITY) SHALL be granted.
REQ-018 Round robin: an internal PORTS-bit mask SHALL be kept; if (request & mask)≠0, the highest-priority masked requester SHALL be granted, otherwise the highest-priority unmasked requester.
REQ-019 On each round-robin grant to index k, the mask SHALL become all-ones<<(k+1) when LSB is high priority, else all-ones>>(PORTS−k).
REQ-020 When not holding and request=0, grant, grant_valid and grant_encoded SHALL become 0 next cycle, and the mask SHALL be retained.
REQ-021 Acknowledge on a non-granted port SHALL be ignored; acknowledge and a new request in the same cycle SHALL re-arbitrate in that cycle, with the result visible next cycle.
REQ-022 PORTS=1 SHALL work, with grant_encoded treated as a 1-bit constant 0.

Reset
REQ-023 While rst=1, grant, grant_valid, grant_encoded and mask SHALL be 0 immediately, without waiting for a clock edge.
REQ-024 After reset deasserts, the first round-robin grant SHALL use unmasked priority.
REQ-025 A reset mid-hold SHALL drop the grant immediately.

Configuration
REQ-026 With macro AXIS_ARBITER_ASSERT_EN defined, simulation assertions SHALL check one-hot grant, grant_valid consistency, grant⊆previous request, and hold correctness.
REQ-027 Without AXIS_ARBITER_ASSERT_EN, no assertion code SHALL be compiled, and behaviour SHALL be identical.

Structure
REQ-028 Package axis_arbiter_pkg SHALL hold the arbitration-type constants (ARB_FIXED=0, ARB_RR=1) and a clog2-safe width function.
REQ-029 One sub-module, axis_arbiter_prio_enc, SHALL implement the priority encoder (parameters WIDTH and LSB_HIGH_PRIORITY; outputs valid, encoded, one-hot), instantiated twice for unmasked and masked requests.

Verification
REQ-030 Fixed priority, LSB, no block, PORTS=4: request=4'b1010 -> next cycle grant=4'b0010, grant_encoded=1, grant_valid=1; request=0 -> grant=0, grant_valid=0.
REQ-031 Fixed priority, MSB: request=4'b0110 -> grant=4'b0100, grant_encoded=2.
REQ-032 Round robin, LSB, no block: request=4'b1111 held for 5 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-033 ARB_BLOCK=1, ARB_BLOCK_ACK=1: port 2 granted; request drops to 4'b0001 without acknowledge -> grant stays 4'b0100; acknowledge=4'b0100 -> next cycle grant=4'b0001.
REQ-034 ARB_BLOCK=1, ARB_BLOCK_ACK=0: port 0 granted; request=4'b0011 kept -> grant stays 4'b0001; request=4'b0010 -> grant=4'b0010.
REQ-035 Async reset: assert rst between clock edges while grant=4'b1000 -> grant=0 and grant_valid=0 before the next edge.
